// File: rtl/seq_divider_16by8_pkg.sv
// ============================================================================
// Module : seq_divider_16by8_pkg
// Brief  : Shared widths and FSM state encodings for the 16/8 sequential divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_divider_16by8_pkg;

    localparam int C_DW = 16;
    localparam int C_VW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_16by8_step.sv
// ============================================================================
// Module : div_restore_step
// Brief  : One combinational restoring-division step (shift, compare, subtract).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_restore_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   r,
    input  logic          dvd_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   r_next,
    output logic          q_bit
);

    logic [VW+1:0] w_shift;
    logic [VW:0]   w_diff;

    // r < divisor on entry, so the shifted value stays below 2*divisor and
    // the difference always fits in VW+1 bits.
    assign w_shift = {r, dvd_bit};
    assign q_bit   = (w_shift >= {2'b00, divisor});
    assign w_diff  = w_shift[VW:0] - {1'b0, divisor};
    assign r_next  = q_bit ? w_diff : w_shift[VW:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider_16by8.sv
// ============================================================================
// Module : seq_divider_16by8
// Brief  : Iterative restoring divider, 16-bit / 8-bit, one quotient bit per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider_16by8
    import seq_divider_16by8_pkg::*;
#(
    parameter int DW = C_DW,
    parameter int VW = C_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_shift;
    logic [VW-1:0] r_divisor;
    logic [VW:0]   r_rem;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_dbz;
    logic [VW:0]   w_rem_next;
    logic          w_q_bit;

    div_restore_step #(
        .VW (VW)
    ) u_step (
        .r       (r_rem),
        .dvd_bit (r_shift[DW-1]),
        .divisor (r_divisor),
        .r_next  (w_rem_next),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_count == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_shift starts as the dividend; each step consumes its MSB and shifts a
    // quotient bit in at the LSB, so after DW steps it holds the quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_rem     <= '0;
                        r_count   <= CW'(DW - 1);
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend[VW-1:0];
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_shift <= {r_shift[DW-2:0], w_q_bit};
                    r_rem   <= w_rem_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_quotient  <= {r_shift[DW-2:0], w_q_bit};
                        r_remainder <= w_rem_next[VW-1:0];
                        r_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_16by8.sv
// ============================================================================
// Module : tb_seq_divider_16by8
// Brief  : Self-checking bench for seq_divider_16by8 (vector table + corner sequences).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider_16by8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge; waits for in_ready, then presents one operand pair.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_timeout", 32'(t < 100), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts posedges after the accept edge until out_valid is seen at a negedge.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [15:0] hq;
        logic [7:0]  hr;
        logic        hd;
        logic        seen;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] eq;
        logic [7:0]  er;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{16'd10200, 8'd200, 16'd51,    8'd0,   1'b0};
        vecs[1]  = '{16'd100,   8'd7,   16'd14,    8'd2,   1'b0};
        vecs[2]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
        vecs[3]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
        vecs[4]  = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1};
        vecs[5]  = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0};
        vecs[6]  = '{16'd300,   8'd3,   16'd100,   8'd0,   1'b0};
        vecs[7]  = '{16'd12345, 8'd100, 16'd123,   8'd45,  1'b0};
        vecs[8]  = '{16'd7,     8'd9,   16'd0,     8'd7,   1'b0};
        vecs[9]  = '{16'd65535, 8'd2,   16'd32767, 8'd1,   1'b0};
        vecs[10] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1};
        vecs[11] = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);

        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_quotient",  32'(quotient),    32'd0);
        check("rst_remainder", 32'(remainder),   32'd0);
        check("rst_dbz",       32'(div_by_zero), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: nonzero divisor -> 16 edges, zero divisor -> valid right after accept.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check("vec_quotient",  32'(quotient),    32'(vecs[i].q));
            check("vec_remainder", 32'(remainder),   32'(vecs[i].r));
            check("vec_dbz",       32'(div_by_zero), 32'(vecs[i].dbz));
            check("vec_latency",   32'(lat),         (vecs[i].b == 8'd0) ? 32'd0 : 32'd16);
        end

        // Backpressure, plus a competing operand offered while DONE.
        @(negedge clk);
        out_ready = 1'b0;
        start_op(16'd100, 8'd7);
        wait_valid(lat);
        hq = quotient;
        hr = remainder;
        hd = div_by_zero;
        check("bp_q_initial", 32'(hq), 32'd14);
        in_valid = 1'b1;
        dividend = 16'd999;
        divisor  = 8'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid),   32'd1);
            check("bp_in_ready",  32'(in_ready),    32'd0);
            check("bp_q_stable",  32'(quotient),    32'(hq));
            check("bp_r_stable",  32'(remainder),   32'(hr));
            check("bp_dbz_stable",32'(div_by_zero), 32'(hd));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("overlap_q",   32'(quotient),  32'd333);
        check("overlap_r",   32'(remainder), 32'd0);
        check("overlap_lat", 32'(lat),       32'd16);

        // Reset in the middle of an iteration run.
        @(negedge clk);
        start_op(16'd5000, 8'd7);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_quotient",  32'(quotient),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        start_op(16'd300, 8'd3);
        wait_valid(lat);
        check("postrst_q", 32'(quotient),  32'd100);
        check("postrst_r", 32'(remainder), 32'd0);

        // Random sweep with random consumer stalls.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start_op(ra, rb);
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (rb == 8'd0) begin
                eq = 16'hFFFF;
                er = ra[7:0];
            end else begin
                eq = ra / 16'(rb);
                er = 8'(ra % 16'(rb));
            end
            check("rand_q",   32'(quotient),    32'(eq));
            check("rand_r",   32'(remainder),   32'(er));
            check("rand_dbz", 32'(div_by_zero), 32'(rb == 8'd0));
            if (rb != 8'd0) begin
                check("rand_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
